// File: rtl/sop_gate_pkg.sv
// Shared defaults and operand bit-index helper for the sum-of-products gate array.
package sop_gate_pkg;

  localparam int DEF_CH    = 2;
  localparam int DEF_TERMS = 2;
  localparam int DEF_WIDTH = 3;
  localparam int DEF_CNTW  = 8;

  // Flat position of input b of term t of channel c within in_data / cfg_mask.
  function automatic int bit_index(input int c, input int t, input int b,
                                   input int terms, input int width);
    return (c * terms + t) * width + b;
  endfunction

endpackage

// File: rtl/sop_term.sv
// One masked AND product term: disabled inputs read as 1, a fully disabled term reads as 0.
module sop_term #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] mask,
  output logic             y
);

  assign y = (|mask) & (&(data | ~mask));

endmodule

// File: rtl/sop_gate_array.sv
// Two-stage pipelined array of masked AND-OR channels with valid/ready flow control and hit counters.
// Build macro SOP_GATE_INVERT_EN adds cfg_inv, turning each channel into an AND-OR-INVERT on demand.
module sop_gate_array
  import sop_gate_pkg::*;
#(
  parameter int CH    = DEF_CH,
  parameter int TERMS = DEF_TERMS,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CH*TERMS*WIDTH-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      cfg_we,
  input  logic [CH*TERMS*WIDTH-1:0] cfg_mask,
`ifdef SOP_GATE_INVERT_EN
  input  logic [CH-1:0]             cfg_inv,
`endif
  output logic [CH-1:0]             out_y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CH*CNTW-1:0]        hit_cnt
);

  localparam int NBITS  = CH * TERMS * WIDTH;
  localparam int NTERMS = CH * TERMS;

  logic [NBITS-1:0]          mask_q;
  logic [CH-1:0]             inv_q;
  logic [NTERMS-1:0]         term_res;
  logic [NTERMS-1:0]         s1_terms;
  logic                      s1_valid;
  logic [CH-1:0]             ch_or;
  logic [CH-1:0]             s2_y;
  logic                      s2_valid;
  logic                      s1_adv;
  logic                      s2_adv;
  logic [CH-1:0][CNTW-1:0]   cnt_q;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    for (genvar t = 0; t < TERMS; t++) begin : g_term
      localparam int BASE = bit_index(c, t, 0, TERMS, WIDTH);
      sop_term #(.WIDTH(WIDTH)) u_term (
        .data (in_data[BASE +: WIDTH]),
        .mask (mask_q[BASE +: WIDTH]),
        .y    (term_res[c*TERMS+t])
      );
    end
  end

  // Terms evaluate against the registered mask, so a load on the accept edge only affects later inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= '1;
    end else if (cfg_we) begin
      mask_q <= cfg_mask;
    end
  end

`ifdef SOP_GATE_INVERT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inv_q <= '0;
    end else if (cfg_we) begin
      inv_q <= cfg_inv;
    end
  end
`else
  assign inv_q = '0;
`endif

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_terms <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      s1_terms <= term_res;
    end
  end

  always_comb begin
    ch_or = '0;
    for (int c = 0; c < CH; c++) begin
      ch_or[c] = |s1_terms[c*TERMS +: TERMS];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      s2_y     <= ch_or ^ inv_q;
    end
  end

  assign out_y     = s2_y;
  assign out_valid = s2_valid;

  // Counters track the value actually delivered downstream and stick at full scale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (s2_valid && out_ready) begin
      for (int c = 0; c < CH; c++) begin
        if (s2_y[c] && (cnt_q[c] != {CNTW{1'b1}})) begin
          cnt_q[c] <= cnt_q[c] + CNTW'(1);
        end
      end
    end
  end

  assign hit_cnt = cnt_q;

endmodule

// File: tb/tb_sop_gate_array.sv
// Scoreboard bench for sop_gate_array at default parameters; covers SOP_GATE_INVERT_EN when defined.
module tb_sop_gate_array;

  logic        clk;
  logic        rst_n;
  logic [11:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        cfg_we;
  logic [11:0] cfg_mask;
`ifdef SOP_GATE_INVERT_EN
  logic [1:0]  cfg_inv;
`endif
  logic [1:0]  out_y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] hit_cnt;

  int          checks;
  int          errors;
  logic [1:0]  sb[$];
  logic [1:0]  exp_y;

  logic [11:0] stream_data [10] = '{12'h007, 12'h038, 12'h1C0, 12'hE00, 12'hE07,
                                    12'h000, 12'h03F, 12'h1FF, 12'h006, 12'hDB6};
  logic [1:0]  stream_exp  [10] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11,
                                    2'b00, 2'b01, 2'b11, 2'b00, 2'b00};

  sop_gate_array #(.CH(2), .TERMS(2), .WIDTH(3), .CNTW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cfg_we    (cfg_we),
    .cfg_mask  (cfg_mask),
`ifdef SOP_GATE_INVERT_EN
    .cfg_inv   (cfg_inv),
`endif
    .out_y     (out_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hit_cnt   (hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

  // Holds the vector until accepted, then records its expected result for the monitor.
  task automatic apply_stimulus(input logic [11:0] d, input logic [1:0] e);
    int guard = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) fail_now("accept_wait");
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load_cfg(input logic [11:0] m);
    cfg_mask = m;
    cfg_we   = 1'b1;
    @(posedge clk);
    #1;
    cfg_we   = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) fail_now("drain");
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every output transfer and checks held data against the queue head while stalled.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output actual=%0h required=none", out_y);
        end else begin
          exp_y = sb.pop_front();
          check_val("out_y", {30'd0, out_y}, {30'd0, exp_y});
        end
      end else if (sb.size() != 0) begin
        check_val("stall_hold", {30'd0, out_y}, {30'd0, sb[0]});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    cfg_we    = 1'b0;
    cfg_mask  = '1;
    out_ready = 1'b1;
`ifdef SOP_GATE_INVERT_EN
    cfg_inv   = 2'b00;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", {31'd0, out_valid}, 0);
    check_val("rst_out_y", {30'd0, out_y}, 0);
    check_val("rst_hit_cnt", {16'd0, hit_cnt}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk);
    #1;

    // Default all-ones mask, exact two-cycle latency.
    in_data  = 12'h007;
    in_valid = 1'b1;
    sb.push_back(2'b01);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val("lat1_out_valid", {31'd0, out_valid}, 0);
    @(posedge clk);
    #1;
    check_val("lat2_out_valid", {31'd0, out_valid}, 1);
    check_val("lat2_out_y", {30'd0, out_y}, 2'b01);
    drain();

    // Channel 1 in two-input mode, then a fully disabled term on channel 0.
    load_cfg(12'h6FF);
    apply_stimulus(12'h600, 2'b10);
    apply_stimulus(12'h800, 2'b00);
    load_cfg(12'h6C7);
    apply_stimulus(12'h038, 2'b00);
    apply_stimulus(12'h000, 2'b00);
    drain();

    // Mask load on the accept edge applies only from the next input.
    cfg_mask = 12'hFFF;
    cfg_we   = 1'b1;
    apply_stimulus(12'h038, 2'b00);
    cfg_we   = 1'b0;
    apply_stimulus(12'h038, 2'b01);
    drain();

    // Back-to-back stream with a three-cycle downstream stall.
    fork
      begin
        for (int i = 0; i < 10; i++) apply_stimulus(stream_data[i], stream_exp[i]);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_val("full_in_ready", {31'd0, in_ready}, 0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Fill both stages under stall, then reset: nothing may be delivered or counted.
    out_ready = 1'b0;
    in_data   = 12'h007;
    in_valid  = 1'b1;
    sb.push_back(2'b01);
    @(posedge clk);
    #1;
    sb.push_back(2'b01);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val("full_out_valid", {31'd0, out_valid}, 1);
    check_val("full_in_ready2", {31'd0, in_ready}, 0);
    rst_n     = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    check_val("midrst_out_valid", {31'd0, out_valid}, 0);
    check_val("midrst_hit_cnt", {16'd0, hit_cnt}, 0);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_val("midrst_no_output", {31'd0, out_valid}, 0);
    end
    check_val("midrst_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk);
    #1;

    // Counter growth and saturation on channel 0 only.
    for (int i = 0; i < 100; i++) apply_stimulus(12'h007, 2'b01);
    drain();
    check_val("hit0_100", {24'd0, hit_cnt[7:0]}, 100);
    check_val("hit1_100", {24'd0, hit_cnt[15:8]}, 0);
    for (int i = 0; i < 200; i++) apply_stimulus(12'h007, 2'b01);
    drain();
    check_val("hit0_sat", {24'd0, hit_cnt[7:0]}, 255);
    check_val("hit1_sat", {24'd0, hit_cnt[15:8]}, 0);

`ifdef SOP_GATE_INVERT_EN
    // Channel 0 inverted: all-zero inputs read as 01.
    cfg_inv = 2'b01;
    load_cfg(12'hFFF);
    apply_stimulus(12'h000, 2'b01);
    apply_stimulus(12'hE00, 2'b11);
    apply_stimulus(12'h007, 2'b00);
    drain();
    check_val("inv_hit1", {24'd0, hit_cnt[15:8]}, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
